// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: drives an external round datapath and key-schedule
// step through ten rounds per job, with a WAIT watchdog and output handshake.
module aes_round_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         rnd_start_o,
    output logic [127:0] rnd_state_o,
    output logic [127:0] rnd_key_o,
    output logic         rnd_last_o,
    input  logic [127:0] rnd_result_i,
    input  logic         rnd_done_i,
    output logic [127:0] ks_key_o,
    output logic [7:0]   ks_rcon_o,
    input  logic [127:0] ks_next_i,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [3:0] WDOG_LIMIT = 4'd15;

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] key_reg, key_next;
    logic [7:0]   rcon_reg, rcon_next;
    logic [3:0]   round_reg, round_next;
    logic [3:0]   wdog_reg, wdog_next;
    logic         last_round;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign last_round  = (round_reg == LAST_ROUND);
    assign rnd_state_o = state_reg;
    assign ks_key_o    = key_reg;
    assign ks_rcon_o   = rcon_reg;
    assign busy        = (fsm_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rcon_reg  <= 8'h01;
            round_reg <= '0;
            wdog_reg  <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            key_reg   <= key_next;
            rcon_reg  <= rcon_next;
            round_reg <= round_next;
            wdog_reg  <= wdog_next;
        end
    end

    always_comb begin
        fsm_next    = fsm_reg;
        state_next  = state_reg;
        key_next    = key_reg;
        rcon_next   = rcon_reg;
        round_next  = round_reg;
        wdog_next   = wdog_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        rnd_start_o = 1'b0;
        rnd_key_o   = key_reg;
        rnd_last_o  = 1'b0;
        err         = 1'b0;

        case (fsm_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = in_data ^ in_key;
                    key_next   = in_key;
                    rcon_next  = 8'h01;
                    round_next = 4'd1;
                    fsm_next   = ISSUE;
                end
            end
            ISSUE: begin
                // The round key is presented combinationally this cycle and
                // captured into key_reg, so rnd_key_o stays stable in WAIT.
                rnd_start_o = 1'b1;
                rnd_key_o   = ks_next_i;
                rnd_last_o  = last_round;
                key_next    = ks_next_i;
                rcon_next   = xtime(rcon_reg);
                wdog_next   = '0;
                fsm_next    = WAIT;
            end
            WAIT: begin
                rnd_last_o = last_round;
                if (rnd_done_i) begin
                    state_next = rnd_result_i;
                    if (last_round) begin
                        fsm_next = DONE;
                    end else begin
                        round_next = round_reg + 4'd1;
                        fsm_next   = ISSUE;
                    end
                end else if (wdog_reg == WDOG_LIMIT) begin
                    // Datapath stalled: drop the job, scrub the state.
                    err        = 1'b1;
                    state_next = '0;
                    wdog_next  = '0;
                    fsm_next   = IDLE;
                end else begin
                    wdog_next = wdog_reg + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = state_reg;
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid input 1, in_ready output 1, in_data input 128 (plaintext), in_key input 128 (cipher key); a job is accepted on a cycle with in_valid & in_ready.
REQ-004 SHALL have ports: out_valid output 1, out_ready input 1, out_data output 128 (ciphertext); a result transfers on a cycle with out_valid & out_ready.
REQ-005 SHALL have round-datapath ports: rnd_start_o output 1 (one-cycle issue pulse), rnd_state_o output 128, rnd_key_o output 128, rnd_last_o output 1 (selects final round, no MixColumns), rnd_result_i input 128, rnd_done_i input 1 (result valid).
REQ-006 SHALL have key-schedule ports: ks_key_o output 128 (current round key), ks_rcon_o output 8, ks_next_i input 128 (next round key, combinational from ks_key_o/ks_rcon_o).
REQ-007 SHALL have status ports: busy output 1 (state != IDLE), err output 1 (one-cycle timeout pulse).

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-009 SHALL drive in_ready = 1 only in IDLE; in_valid in other states SHALL be ignored, with no state change.
REQ-010 On accept in IDLE: state_reg <= in_data ^ in_key (round-0 AddRoundKey), key_reg <= in_key, rcon <= 8'h01, round <= 1, next state ISSUE.
REQ-011 ISSUE, one cycle only:
- rnd_start_o = 1; rnd_state_o = state_reg; rnd_key_o = ks_next_i; rnd_last_o = (round == 10).
- At the clock edge: key_reg <= ks_next_i; rcon <= xtime(rcon); next state WAIT.
REQ-012 xtime rules: rcon<<1 when rcon[7]=0; (rcon<<1)^8'h1b when rcon[7]=1.
- Rounds 1..10 SHALL use rcon 01,02,04,08,10,20,40,80,1b,36.
REQ-013 ks_key_o SHALL equal key_reg and ks_rcon_o SHALL equal rcon at all times.
REQ-014 rnd_state_o, rnd_key_o and rnd_last_o SHALL be held stable through WAIT.
REQ-015 WAIT, rnd_done_i = 1:
- state_reg <= rnd_result_i.
- round == 10: next state DONE.
- otherwise: round <= round + 1; next state ISSUE.
REQ-016 rnd_done_i SHALL be ignored outside WAIT, including in the ISSUE cycle.
REQ-017 Watchdog: a 4-bit counter, cleared on entry to WAIT, SHALL increment each WAIT cycle without rnd_done_i.
- On the 16th such cycle (counter == 15), SHALL pulse err for one cycle, clear state_reg, and return to IDLE without producing an output.
REQ-018 DONE:
- out_valid = 1; out_data = state_reg.
- out_data SHALL be held stable while out_valid & ~out_ready.
- On the out_ready handshake: next state IDLE; out_valid deasserts the following cycle.
REQ-019 out_valid SHALL never assert outside DONE; a new job SHALL be accepted no earlier than the cycle after the output handshake.
REQ-020 Latency, single-cycle datapath (rnd_done_i the cycle after rnd_start_o):
- Round r issued in cycle 2r-1 after the accept edge.
- out_valid first high in cycle 21 after the accept edge.
REQ-021 round SHALL be a 4-bit counter that never exceeds 10.

Reset
REQ-022 rst_n low SHALL asynchronously force:
- state IDLE; round 0; rcon 8'h01; watchdog 0.
- state_reg 0; key_reg 0.
- in_ready 1; out_valid 0; out_data 0; rnd_start_o 0; rnd_last_o 0; busy 0; err 0.
REQ-023 Reset mid-operation SHALL abandon the job with no out_valid.
- The first accept after rst_n rises SHALL proceed normally.

Verification
REQ-024 FIPS-197 C.1, model datapath with 1-cycle latency:
- in_data 00112233445566778899aabbccddeeff, in_key 000102030405060708090a0b0c0d0e0f.
- out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid in cycle 21.
- rnd_start_o pulses 10 times; rnd_last_o high on the 10th pulse only.
REQ-025 Rcon trace: ks_rcon_o across the 10 ISSUE cycles SHALL read 01,02,04,08,10,20,40,80,1b,36.
REQ-026 Backpressure and busy:
- out_ready held low 5 cycles in DONE -> out_valid stays 1 and out_data is unchanged.
- in_valid pulsed during round 4 -> in_ready 0, job unaffected.
REQ-027 Timeout: datapath withholds rnd_done_i in round 3 -> err pulses once 16 WAIT cycles after round-3 entry to WAIT, FSM returns to IDLE, in_ready 1, out_valid never asserts.
REQ-028 Reset in round 6 -> all outputs at reset values immediately; a fresh C.1 job then yields 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-029 Back-to-back jobs with out_ready tied high -> each job's output correct; second accept occurs in the cycle after the first output handshake.
